// File: rtl/alu_sched_if.sv
// Bundle of request, ALU and response signals shared between alu_sched and its environment.
interface alu_sched_if #(parameter int CNT_W = 8);
  logic             req0_valid;
  logic             req0_ready;
  logic [7:0]       req0_a;
  logic [7:0]       req0_b;
  logic [2:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [7:0]       req1_a;
  logic [7:0]       req1_b;
  logic [2:0]       req1_op;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_op;
  logic [7:0]       alu_res;
  logic             alu_ac;
  logic             alu_c;
  logic             alu_z;
  logic             alu_s;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [7:0]       rsp_res;
  logic             rsp_ac;
  logic             rsp_c;
  logic             rsp_z;
  logic             rsp_s;
  logic             busy;
  logic [CNT_W-1:0] op_cnt;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_res, alu_ac, alu_c, alu_z, alu_s,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_res, rsp_ac, rsp_c, rsp_z, rsp_s,
    output busy, op_cnt
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_res, alu_ac, alu_c, alu_z, alu_s,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_res, rsp_ac, rsp_c, rsp_z, rsp_s,
    input  busy, op_cnt
  );
endinterface

// File: rtl/alu_sched.sv
// Two-requester scheduler for the shared combinational 8-bit ALU: IDLE -> EXEC -> RESP.
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_sched #(
  parameter int CNT_W = 8
) (
  input logic       clk,
  input logic       rst,
  alu_sched_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg;
  logic             last_grant_reg;
  logic [7:0]       iss_a_reg;
  logic [7:0]       iss_b_reg;
  logic [2:0]       iss_op_reg;
  logic             iss_id_reg;
  logic             rsp_valid_reg;
  logic             rsp_id_reg;
  logic [7:0]       rsp_res_reg;
  logic [3:0]       rsp_flags_reg;
  logic             busy_reg;
  logic [CNT_W-1:0] op_cnt_reg;

  logic [1:0]       req_valid;
  logic [7:0]       req_a [2];
  logic [7:0]       req_b [2];
  logic [2:0]       req_op [2];
  logic [1:0]       grant;
  logic [1:0]       ready;
  logic             prefer;
  logic             accept;
  logic             accept_id;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_a[0]  = bus.req0_a;
  assign req_a[1]  = bus.req1_a;
  assign req_b[0]  = bus.req0_b;
  assign req_b[1]  = bus.req1_b;
  assign req_op[0] = bus.req0_op;
  assign req_op[1] = bus.req1_op;

  // prefer names the requester that wins when both are valid
`ifdef ALU_SCHED_RR_EN
  assign prefer = ~last_grant_reg;
`else
  logic unused_last_grant;
  assign prefer = 1'b0;
  assign unused_last_grant = last_grant_reg;
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_arb
      assign grant[gi] = req_valid[gi] && (!req_valid[1-gi] || (prefer == 1'(gi)));
      assign ready[gi] = grant[gi] && (state_reg == IDLE) && !rst;
    end
  endgenerate

  assign accept    = |ready;
  assign accept_id = ready[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      iss_a_reg      <= '0;
      iss_b_reg      <= '0;
      iss_op_reg     <= '0;
      iss_id_reg     <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_res_reg    <= '0;
      rsp_flags_reg  <= '0;
      busy_reg       <= 1'b0;
      op_cnt_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            iss_a_reg      <= req_a[accept_id];
            iss_b_reg      <= req_b[accept_id];
            iss_op_reg     <= req_op[accept_id];
            iss_id_reg     <= accept_id;
            last_grant_reg <= accept_id;
            busy_reg       <= 1'b1;
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          // The ALU has had the whole cycle to settle on the issue registers.
          rsp_res_reg   <= bus.alu_res;
          rsp_flags_reg <= {bus.alu_ac, bus.alu_c, bus.alu_z, bus.alu_s};
          rsp_id_reg    <= iss_id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            op_cnt_reg    <= op_cnt_reg + 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.alu_a      = iss_a_reg;
  assign bus.alu_b      = iss_b_reg;
  assign bus.alu_op     = iss_op_reg;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_id     = rsp_id_reg;
  assign bus.rsp_res    = rsp_res_reg;
  assign bus.rsp_ac     = rsp_flags_reg[3];
  assign bus.rsp_c      = rsp_flags_reg[2];
  assign bus.rsp_z      = rsp_flags_reg[1];
  assign bus.rsp_s      = rsp_flags_reg[0];
  assign bus.busy       = busy_reg;
  assign bus.op_cnt     = op_cnt_reg;
endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: a request driver pushes expected responses, a monitor pops and compares.
module tb_alu_sched;
  localparam int M_DIR  = 0;
  localparam int M_HOLD = 1;
  localparam int M_RND  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_sched_if #(.CNT_W(8)) ifc ();
  alu_sched #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic [3:0] fl;
    int         acc;
  } txn_t;

  txn_t       expq[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         n_rsp = 0;
  int         to_cnt = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       exp_r0 = 1'b0;
  logic       exp_r1 = 1'b0;

  logic [1:0] v = 2'b00;
  logic [1:0] acc_last = 2'b00;
  logic [7:0] ra [2];
  logic [7:0] rb [2];
  logic [2:0] rop [2];
  logic       last_g = 1'b1;
  int         mode = M_DIR;
  logic       use_lit = 1'b0;
  logic [7:0] lit_res = 8'd0;
  logic [3:0] lit_fl = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: result plus {AC, C, Z, S}, computed with plain integer arithmetic.
  function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int ia, ib, r;
    logic c, ac;
    logic [7:0] res;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    c  = 1'b0;
    ac = 1'b0;
    case (op)
      3'd0: begin r = ia + ib; c = (r > 255); ac = ((ia % 16) + (ib % 16)) > 15; end
      3'd1: begin r = ia - ib; c = (ia < ib); ac = ((ia % 16) < (ib % 16)); end
      3'd2: begin r = 256 - ia; c = (ia != 0); ac = ((ia % 16) != 0); end
      3'd3: r = ia & ib;
      3'd4: r = ia | ib;
      3'd5: r = 255 - (ia & ib);
      3'd6: r = 255 - (ia | ib);
      default: r = ia ^ ib;
    endcase
    res = 8'(r);
    return {res, ac, c, (res == 8'd0), res[7]};
  endfunction

  always_comb begin
    {ifc.alu_res, ifc.alu_ac, ifc.alu_c, ifc.alu_z, ifc.alu_s} = alu_fn(ifc.alu_a, ifc.alu_b, ifc.alu_op);
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic new_req(input int i);
    v[i]   = 1'b1;
    ra[i]  = 8'($urandom);
    rb[i]  = 8'($urandom);
    rop[i] = 3'($urandom_range(0, 7));
  endtask

  // One clock of stimulus: update requests after the edge, then predict readys and push accepts.
  task automatic cycle(input logic r);
    logic [1:0]  g;
    logic        idx;
    logic [11:0] f;
    txn_t        t;
    @(posedge clk);
    #1;
    rst = r;
    if (r) begin
      expq.delete();
      last_g   = 1'b1;
      v        = 2'b00;
      acc_last = 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (acc_last[i]) begin
          if (mode == M_RND && $urandom_range(0, 1) == 1) new_req(i);
          else if (mode != M_HOLD) v[i] = 1'b0;
        end else if (mode == M_RND) begin
          if (!v[i]) begin
            if ($urandom_range(0, 2) == 0) new_req(i);
          end else if ($urandom_range(0, 15) == 0) begin
            v[i] = 1'b0;
          end
        end
      end
    end
    if (mode == M_RND) ifc.rsp_ready = ($urandom_range(0, 3) != 0);
    ifc.req0_valid = v[0];
    ifc.req0_a     = ra[0];
    ifc.req0_b     = rb[0];
    ifc.req0_op    = rop[0];
    ifc.req1_valid = v[1];
    ifc.req1_a     = ra[1];
    ifc.req1_b     = rb[1];
    ifc.req1_op    = rop[1];
    #1;
    g = 2'b00;
    if (!r && expq.size() == 0) begin
      if (v[0] && v[1]) begin
`ifdef ALU_SCHED_RR_EN
        g = last_g ? 2'b01 : 2'b10;
`else
        g = 2'b01;
`endif
      end else begin
        g = v;
      end
    end
    exp_r0   = g[0];
    exp_r1   = g[1];
    acc_last = g;
    if (g != 2'b00) begin
      idx   = g[1];
      f     = alu_fn(ra[idx], rb[idx], rop[idx]);
      t.id  = idx;
      t.a   = ra[idx];
      t.b   = rb[idx];
      t.op  = rop[idx];
      t.res = use_lit ? lit_res : f[11:4];
      t.fl  = use_lit ? lit_fl : f[3:0];
      t.acc = cyc;
      expq.push_back(t);
      last_g = idx;
    end
  endtask

  task automatic wait_idle(input int bound);
    for (int n = 0; n < bound; n++) begin
      cycle(1'b0);
      if (v == 2'b00 && expq.size() == 0) return;
    end
    to_cnt++;
    v = 2'b00;
  endtask

  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    v[i]   = 1'b1;
    ra[i]  = a;
    rb[i]  = b;
    rop[i] = op;
  endtask

  // Response monitor: pops the scoreboard whenever the DUT completes a handshake.
  initial begin : mon
    txn_t t;
    logic have, exp_busy, exp_valid, rst_prev;
    int   to_seen;
    rst_prev = 1'b0;
    to_seen  = 0;
    forever begin
      @(negedge clk);
      if (to_cnt != to_seen) begin
        chk("timeout", to_cnt, to_seen);
        to_seen = to_cnt;
      end
      chk("req0_ready", ifc.req0_ready, exp_r0);
      chk("req1_ready", ifc.req1_ready, exp_r1);
      if (rst) begin
        exp_cnt  = 8'd0;
        rst_prev = 1'b1;
      end else begin
        if (rst_prev) begin
          chk("reset_alu", {ifc.alu_a, ifc.alu_b, ifc.alu_op}, 0);
          chk("reset_rsp", {ifc.rsp_id, ifc.rsp_res, ifc.rsp_ac, ifc.rsp_c, ifc.rsp_z, ifc.rsp_s}, 0);
          rst_prev = 1'b0;
        end
        have = (expq.size() != 0);
        if (have) t = expq[0];
        exp_busy  = have && (cyc > t.acc);
        exp_valid = have && (cyc >= t.acc + 2);
        chk("busy", ifc.busy, exp_busy);
        chk("rsp_valid", ifc.rsp_valid, exp_valid);
        chk("op_cnt", ifc.op_cnt, exp_cnt);
        if (exp_busy) chk("alu_inputs", {ifc.alu_a, ifc.alu_b, ifc.alu_op}, {t.a, t.b, t.op});
        if (exp_valid && ifc.rsp_valid) begin
          chk("rsp_id", ifc.rsp_id, t.id);
          chk("rsp_res", ifc.rsp_res, t.res);
          chk("rsp_flags", {ifc.rsp_ac, ifc.rsp_c, ifc.rsp_z, ifc.rsp_s}, t.fl);
          if (ifc.rsp_ready) begin
            void'(expq.pop_front());
            exp_cnt = exp_cnt + 8'd1;
            n_rsp++;
            $display("[TB] rsp %0d: id=%0d a=%02h b=%02h op=%0d res=%02h acczs=%04b op_cnt->%0d",
                     n_rsp, ifc.rsp_id, t.a, t.b, t.op, ifc.rsp_res,
                     {ifc.rsp_ac, ifc.rsp_c, ifc.rsp_z, ifc.rsp_s}, exp_cnt);
          end
        end
      end
    end
  end

  initial begin
    ifc.rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ra[i]  = 8'd0;
      rb[i]  = 8'd0;
      rop[i] = 3'd0;
    end
    repeat (3) cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);

    // ADD 0x0F + 0x01 on port 0, then ADD 0xFF + 0x01 on port 1
    ifc.rsp_ready = 1'b1;
    mode    = M_DIR;
    use_lit = 1'b1;
    lit_res = 8'h10;
    lit_fl  = 4'b1000;
    issue(0, 8'h0F, 8'h01, 3'd0);
    wait_idle(40);
    lit_res = 8'h00;
    lit_fl  = 4'b1110;
    issue(1, 8'hFF, 8'h01, 3'd0);
    wait_idle(40);
    use_lit = 1'b0;

    // Both requesters held valid with rsp_ready high
    mode = M_HOLD;
    new_req(0);
    new_req(1);
    repeat (14) cycle(1'b0);
    mode = M_DIR;
    v    = 2'b00;
    wait_idle(40);

    // Backpressure in RESP
    ifc.rsp_ready = 1'b0;
    new_req(0);
    repeat (9) cycle(1'b0);
    ifc.rsp_ready = 1'b1;
    wait_idle(40);

    // Reset while the response is pending
    ifc.rsp_ready = 1'b0;
    new_req(1);
    repeat (3) cycle(1'b0);
    cycle(1'b1);
    ifc.rsp_ready = 1'b1;
    repeat (4) cycle(1'b0);

    // 256 operations: the counter wraps back to zero
    for (int k = 0; k < 256; k++) begin
      new_req($urandom_range(0, 1));
      wait_idle(40);
    end

    // Random traffic with random backpressure
    mode = M_RND;
    repeat (3000) cycle(1'b0);
    mode = M_DIR;
    v    = 2'b00;
    ifc.rsp_ready = 1'b1;
    wait_idle(40);
    repeat (3) cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
